// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time between execute and byte-addressed data memory.
// Checks funct3, alignment and range, strobes memory for one cycle, extends load data,
// and returns the result through a valid/ready response handshake.

`ifndef MEM_ACCESS_WIDTH
`define MEM_ACCESS_WIDTH 2
`endif
`ifndef MEM_ACCESS_BYTE
`define MEM_ACCESS_BYTE  2'd0
`endif
`ifndef MEM_ACCESS_HALF
`define MEM_ACCESS_HALF  2'd1
`endif
`ifndef MEM_ACCESS_WORD
`define MEM_ACCESS_WORD  2'd2
`endif

// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | memory strobe on the bus for this single cycle
// LDATA  | load data returned by memory, extend into resp_rdata
// RESP   | response held until resp_ready

module load_store_unit #(
   parameter int N         = 32,
   parameter int MEM_BYTES = 2048,
   parameter int ALIGN_CHK = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [2:0]                   req_funct3,
   input  logic [N-1:0]                 req_addr,
   input  logic [N-1:0]                 req_wdata,
   output logic                         resp_valid,
   input  logic                         resp_ready,
   output logic [N-1:0]                 resp_rdata,
   output logic                         resp_err,
   output logic [`MEM_ACCESS_WIDTH-1:0] mem_access,
   output logic                         mem_rdEna,
   output logic                         mem_wrEna,
   output logic [N-1:0]                 mem_rdAddr,
   output logic [N-1:0]                 mem_wrAddr,
   output logic [N-1:0]                 mem_wrData,
   input  logic [N-1:0]                 mem_rdData
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LDATA, S_RESP} state_t;

   state_t state, state_nxt;
   logic   lat_we;
   logic [2:0] lat_f3;

   logic [2:0]                   size_bytes;
   logic [`MEM_ACCESS_WIDTH-1:0] access_code;
   logic [N:0]                   end_addr;
   logic                         illegal, misalign, range_err, req_err;
   logic [N-1:0]                 ext_rdata;

   logic                         resp_valid_nxt, resp_err_nxt;
   logic [N-1:0]                 resp_rdata_nxt;
   logic [`MEM_ACCESS_WIDTH-1:0] mem_access_nxt;
   logic                         mem_rdEna_nxt, mem_wrEna_nxt;
   logic [N-1:0]                 mem_rdAddr_nxt, mem_wrAddr_nxt, mem_wrData_nxt;

   assign req_ready = (state == S_IDLE);

   // request decode: size, access code and error classification
   always_comb begin
      case (req_funct3[1:0])
         2'd0:    begin size_bytes = 3'd1; access_code = `MEM_ACCESS_BYTE; end
         2'd1:    begin size_bytes = 3'd2; access_code = `MEM_ACCESS_HALF; end
         default: begin size_bytes = 3'd4; access_code = `MEM_ACCESS_WORD; end
      endcase
      if (req_we)
         illegal = (req_funct3 > 3'd2);
      else
         illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
      misalign = (ALIGN_CHK != 0) &&
                 (((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00)));
      // one extra bit so addresses near the top of the space cannot wrap into range
      end_addr  = {1'b0, req_addr} + {{(N-2){1'b0}}, size_bytes};
      range_err = (end_addr > (N+1)'(MEM_BYTES));
      req_err   = illegal || misalign || range_err;
   end

   // load extension from the little-endian word returned by memory
   always_comb begin
      case (lat_f3)
         3'd0:    ext_rdata = {{(N-8){mem_rdData[7]}}, mem_rdData[7:0]};
         3'd1:    ext_rdata = {{(N-16){mem_rdData[15]}}, mem_rdData[15:0]};
         3'd4:    ext_rdata = {{(N-8){1'b0}}, mem_rdData[7:0]};
         3'd5:    ext_rdata = {{(N-16){1'b0}}, mem_rdData[15:0]};
         default: ext_rdata = mem_rdData;
      endcase
   end

   // state register and latched request attributes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         lat_we <= 1'b0;
         lat_f3 <= 3'd0;
      end else begin
         state <= state_nxt;
         if (req_valid && req_ready) begin
            lat_we <= req_we;
            lat_f3 <= req_funct3;
         end
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req_valid) state_nxt = req_err ? S_RESP : S_ACCESS;
         S_ACCESS: state_nxt = lat_we ? S_RESP : S_LDATA;
         S_LDATA:  state_nxt = S_RESP;
         S_RESP:   if (resp_ready) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // next values of the registered outputs; memory strobes default low so they last one cycle
   always_comb begin
      mem_access_nxt = '0;
      mem_rdEna_nxt  = 1'b0;
      mem_wrEna_nxt  = 1'b0;
      mem_rdAddr_nxt = '0;
      mem_wrAddr_nxt = '0;
      mem_wrData_nxt = '0;
      resp_valid_nxt = resp_valid;
      resp_err_nxt   = resp_err;
      resp_rdata_nxt = resp_rdata;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (req_err) begin
                  resp_valid_nxt = 1'b1;
                  resp_err_nxt   = 1'b1;
                  resp_rdata_nxt = '0;
               end else begin
                  mem_access_nxt = access_code;
                  if (req_we) begin
                     mem_wrEna_nxt  = 1'b1;
                     mem_wrAddr_nxt = req_addr;
                     mem_wrData_nxt = req_wdata;
                  end else begin
                     mem_rdEna_nxt  = 1'b1;
                     mem_rdAddr_nxt = req_addr;
                  end
               end
            end
         end
         S_ACCESS: begin
            if (lat_we) begin
               resp_valid_nxt = 1'b1;
               resp_err_nxt   = 1'b0;
               resp_rdata_nxt = '0;
            end
         end
         S_LDATA: begin
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b0;
            resp_rdata_nxt = ext_rdata;
         end
         S_RESP: begin
            if (resp_ready) begin
               resp_valid_nxt = 1'b0;
               resp_err_nxt   = 1'b0;
               resp_rdata_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   // output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_access <= '0;
         mem_rdEna  <= 1'b0;
         mem_wrEna  <= 1'b0;
         mem_rdAddr <= '0;
         mem_wrAddr <= '0;
         mem_wrData <= '0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
      end else begin
         mem_access <= mem_access_nxt;
         mem_rdEna  <= mem_rdEna_nxt;
         mem_wrEna  <= mem_wrEna_nxt;
         mem_rdAddr <= mem_rdAddr_nxt;
         mem_wrAddr <= mem_wrAddr_nxt;
         mem_wrData <= mem_wrData_nxt;
         resp_valid <= resp_valid_nxt;
         resp_err   <= resp_err_nxt;
         resp_rdata <= resp_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (alignment checking on / off) sharing one memory
// model; a queue holds expected responses and a negedge monitor checks them.

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_ready = 1'b1;
   logic [31:0] mem_rdData = '0;

   logic        rv_a, rv_b, rr_a, rr_b, pv_a, pv_b, pe_a, pe_b;
   logic [31:0] pd_a, pd_b;
   logic [1:0]  acc_a, acc_b;
   logic        rden_a, rden_b, wren_a, wren_b;
   logic [31:0] rda_a, rda_b, wra_a, wra_b, wrd_a, wrd_b;

   assign rv_a = req_valid & ~sel;
   assign rv_b = req_valid & sel;

   load_store_unit #(.N(32), .MEM_BYTES(2048), .ALIGN_CHK(1)) u_a (
      .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rr_a), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(pv_a), .resp_ready(resp_ready), .resp_rdata(pd_a), .resp_err(pe_a),
      .mem_access(acc_a), .mem_rdEna(rden_a), .mem_wrEna(wren_a), .mem_rdAddr(rda_a),
      .mem_wrAddr(wra_a), .mem_wrData(wrd_a), .mem_rdData(mem_rdData));

   load_store_unit #(.N(32), .MEM_BYTES(2048), .ALIGN_CHK(0)) u_b (
      .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rr_b), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(pv_b), .resp_ready(resp_ready), .resp_rdata(pd_b), .resp_err(pe_b),
      .mem_access(acc_b), .mem_rdEna(rden_b), .mem_wrEna(wren_b), .mem_rdAddr(rda_b),
      .mem_wrAddr(wra_b), .mem_wrData(wrd_b), .mem_rdData(mem_rdData));

   logic        vreq_ready, vresp_valid, vresp_err;
   logic [31:0] vresp_rdata;
   assign vreq_ready  = sel ? rr_b : rr_a;
   assign vresp_valid = sel ? pv_b : pv_a;
   assign vresp_err   = sel ? pe_b : pe_a;
   assign vresp_rdata = sel ? pd_b : pd_a;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  lat;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   logic [7:0]  mem [0:2047];

   task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] acc);
      mem[a[10:0]] = d[7:0];
      if (acc != 2'd0) mem[11'(a[10:0] + 11'd1)] = d[15:8];
      if (acc == 2'd2) begin
         mem[11'(a[10:0] + 11'd2)] = d[23:16];
         mem[11'(a[10:0] + 11'd3)] = d[31:24];
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return {mem[11'(a[10:0] + 11'd3)], mem[11'(a[10:0] + 11'd2)],
              mem[11'(a[10:0] + 11'd1)], mem[a[10:0]]};
   endfunction

   // memory model: word returned the cycle after a read strobe, LSB = byte at the address
   always @(posedge clk) begin
      if (wren_a) mem_write(wra_a, wrd_a, acc_a);
      if (wren_b) mem_write(wra_b, wrd_b, acc_b);
      if (rden_a) mem_rdData <= mem_read(rda_a);
      if (rden_b) mem_rdData <= mem_read(rda_b);
      if (rden_a || rden_b || wren_a || wren_b) strobe_cnt++;
      checks++;
      if ((rden_a && wren_a) || (rden_b && wren_b)) begin
         failures++;
         $display("FAIL strobe_overlap: rdEna and wrEna both high at %0t, required exclusive", $time);
      end
      if (req_valid && vreq_ready) cyc = 0;
      else cyc++;
   end

   logic        seen = 1'b0;
   logic [31:0] hold_rdata;
   logic        hold_err;

   // response monitor
   always @(negedge clk) begin
      exp_t e;
      if (vresp_valid) begin
         if (!seen) begin
            seen = 1'b1;
            hold_rdata = vresp_rdata;
            hold_err = vresp_err;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_resp: got resp_valid rdata=%h err=%b, required no response",
                        vresp_rdata, vresp_err);
            end else begin
               e = sb.pop_front();
               if (vresp_rdata !== e.rdata) begin
                  failures++;
                  $display("FAIL resp_rdata: got %h, required %h", vresp_rdata, e.rdata);
               end
               checks++;
               if (vresp_err !== e.err) begin
                  failures++;
                  $display("FAIL resp_err: got %b, required %b", vresp_err, e.err);
               end
               checks++;
               if (cyc + 1 != int'(e.lat)) begin
                  failures++;
                  $display("FAIL latency: got %0d cycles, required %0d", cyc + 1, e.lat);
               end
            end
         end else begin
            checks++;
            if (vresp_rdata !== hold_rdata || vresp_err !== hold_err) begin
               failures++;
               $display("FAIL resp_stable: got rdata=%h err=%b, required rdata=%h err=%b",
                        vresp_rdata, vresp_err, hold_rdata, hold_err);
            end
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic wait_done();
      bit done = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !vresp_valid) begin
            done = 1;
            break;
         end
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL timeout: response not completed within 30 cycles, pending=%0d", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input logic s, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [7:0] exp_lat, input bit wait_resp);
      exp_t e;
      @(negedge clk);
      sel = s;
      req_we = we;
      req_funct3 = f3;
      req_addr = addr;
      req_wdata = wdata;
      req_valid = 1'b1;
      e.rdata = exp_rdata;
      e.err = exp_err;
      e.lat = exp_lat;
      sb.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (wait_resp) wait_done();
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      int sc;
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("reset_outs_a", {30'd0, acc_a, rden_a, wren_a, pv_a, pe_a} | rda_a | wra_a | wrd_a | pd_a, 32'd0);
      check_val("reset_outs_b", {30'd0, acc_b, rden_b, wren_b, pv_b, pe_b} | rda_b | wra_b | wrd_b | pd_b, 32'd0);
      check_val("reset_req_ready", {30'd0, rr_a, rr_b}, 32'd3);

      // store then word load
      issue(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 8'd2, 1);
      issue(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 8'd3, 1);
      // byte/half extension
      issue(0, 0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 8'd3, 1);
      issue(0, 0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 0, 8'd3, 1);
      issue(0, 0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 8'd3, 1);
      issue(0, 0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 0, 8'd3, 1);
      issue(0, 0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 8'd3, 1);
      // byte store writes only the LSB
      issue(0, 1, 3'd0, 32'h20, 32'h12345678, 32'h0, 0, 8'd2, 1);
      issue(0, 0, 3'd2, 32'h20, 32'h0, 32'h00000078, 0, 8'd3, 1);

      // misaligned word with checking on: error, no strobe
      sc = strobe_cnt;
      issue(0, 0, 3'd2, 32'h11, 32'h0, 32'h0, 1, 8'd1, 1);
      check_val("no_strobe_misalign", 32'(strobe_cnt), 32'(sc));
      issue(0, 0, 3'd1, 32'h11, 32'h0, 32'h0, 1, 8'd1, 1);
      // same access with checking off: normal load of bytes 0x11..0x14
      issue(1, 0, 3'd2, 32'h11, 32'h0, 32'h00DEADBE, 0, 8'd3, 1);

      // range and funct3 errors
      sc = strobe_cnt;
      issue(0, 0, 3'd2, 32'h7FE, 32'h0, 32'h0, 1, 8'd1, 1);
      issue(1, 0, 3'd2, 32'h7FE, 32'h0, 32'h0, 1, 8'd1, 1);
      issue(0, 0, 3'd2, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 8'd1, 1);
      issue(0, 0, 3'd3, 32'h10, 32'h0, 32'h0, 1, 8'd1, 1);
      issue(0, 1, 3'd4, 32'h10, 32'h1, 32'h0, 1, 8'd1, 1);
      check_val("no_strobe_errors", 32'(strobe_cnt), 32'(sc));
      // last legal locations
      issue(0, 0, 3'd2, 32'h7FC, 32'h0, 32'h0, 0, 8'd3, 1);
      issue(0, 0, 3'd0, 32'h7FF, 32'h0, 32'h0, 0, 8'd3, 1);

      // back-pressure: response held for 5 cycles
      resp_ready = 1'b0;
      issue(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 8'd3, 0);
      for (int i = 0; i < 10 && !vresp_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("stall_resp_valid", {31'd0, vresp_valid}, 32'd1);
         check_val("stall_req_ready", {31'd0, vreq_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      wait_done();

      // reset pulse while the load strobe is on the bus: no response
      @(negedge clk);
      sel = 1'b0;
      req_we = 1'b0;
      req_funct3 = 3'd2;
      req_addr = 32'h10;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check_val("access_rdEna", {31'd0, rden_a}, 32'd1);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_val("post_reset_req_ready", {31'd0, vreq_ready}, 32'd1);
      check_val("post_reset_no_resp", {31'd0, vresp_valid}, 32'd0);
      check_val("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
